// File: rtl/tow_pkg.sv
// Shared types for the tug-of-war playfield: round state and winner encodings.
package tow_pkg;

  typedef enum logic [1:0] {
    PLAY  = 2'd0,
    WIN_L = 2'd1,
    WIN_R = 2'd2
  } state_t;

  localparam logic [1:0] WIN_NONE  = 2'b00;
  localparam logic [1:0] WIN_LEFT  = 2'b10;
  localparam logic [1:0] WIN_RIGHT = 2'b01;

endpackage

// File: rtl/tow_score_ctr.sv
// Saturating per-player win counter; holds at all-ones instead of wrapping.
module tow_score_ctr #(
  parameter int SCORE_W = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               inc,
  output logic [SCORE_W-1:0] count
);

  localparam logic [SCORE_W-1:0] MAX = '1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                   count <= '0;
    else if (inc && count != MAX) count <= count + 1'b1;
  end

endmodule

// File: rtl/tow_field.sv
// Tug-of-war playfield: rope position, round FSM, score counters and led decode.
module tow_field
  import tow_pkg::*;
#(
  parameter int N_LIGHTS = 9,
  parameter int SCORE_W  = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                l_press,
  input  logic                r_press,
  input  logic                restart,
  output logic [N_LIGHTS-1:0] led,
  output logic                game_over,
  output logic [1:0]          winner,
  output logic [SCORE_W-1:0]  l_score,
  output logic [SCORE_W-1:0]  r_score
);

  localparam int              POS_W = $clog2(N_LIGHTS);
  localparam int              CTR_I = (N_LIGHTS - 1) / 2;
  localparam logic [POS_W-1:0] CTR  = POS_W'(CTR_I);
  localparam logic [POS_W-1:0] LAST = POS_W'(N_LIGHTS - 1);

  state_t                        state, state_nxt;
  logic [POS_W-1:0]              pos, pos_nxt;
  logic [1:0]                    inc;    // [1] left, [0] right, same order as winner
  logic [1:0][SCORE_W-1:0]       score;
  logic                          l_only, r_only;

  assign l_only = l_press & ~r_press;
  assign r_only = r_press & ~l_press;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= PLAY;
      pos   <= CTR;
    end else begin
      state <= state_nxt;
      pos   <= pos_nxt;
    end
  end

  // A win needs a press while already sitting on the edge light.
  always_comb begin
    state_nxt = state;
    pos_nxt   = pos;
    inc       = '0;
    if (restart) begin
      state_nxt = PLAY;
      pos_nxt   = CTR;
    end else if (state == PLAY) begin
      if (l_only) begin
        if (pos == LAST) begin
          state_nxt = WIN_L;
          inc[1]    = 1'b1;
        end else begin
          pos_nxt = pos + 1'b1;
        end
      end else if (r_only) begin
        if (pos == '0) begin
          state_nxt = WIN_R;
          inc[0]    = 1'b1;
        end else begin
          pos_nxt = pos - 1'b1;
        end
      end
    end
  end

  for (genvar p = 0; p < 2; p++) begin : g_score
    tow_score_ctr #(.SCORE_W(SCORE_W)) u_ctr (
      .clk   (clk),
      .reset (reset),
      .inc   (inc[p]),
      .count (score[p])
    );
  end

  assign l_score = score[1];
  assign r_score = score[0];

  always_comb begin
    led       = '0;
    game_over = 1'b0;
    winner    = WIN_NONE;
    case (state)
      WIN_L: begin
        for (int i = 0; i < N_LIGHTS; i++) led[i] = (i > CTR_I);
        game_over = 1'b1;
        winner    = WIN_LEFT;
      end
      WIN_R: begin
        for (int i = 0; i < N_LIGHTS; i++) led[i] = (i < CTR_I);
        game_over = 1'b1;
        winner    = WIN_RIGHT;
      end
      default: led = N_LIGHTS'(1) << pos;
    endcase
  end

endmodule
